rs_alu_unit: RTL and testbench
==============================

# rs_alu_unit

Parametrised integer ALU functional unit with reservation stations for the Tomasulo datapath. It holds up to N_RS issued instructions and captures pending operands by snooping the common data bus (CDB). It dispatches one ready station at a time to a multi-cycle ALU and requests the CDB to broadcast the tagged result. It replaces the fixed three-station adder unit and adds reset, configurable depth, width and latency, issue-time forwarding and illegal-opcode rejection.

## Interface
- N_RS, 3: number of reservation stations (1..8)
- DATA_W, 32: operand/result width
- TAG_W, 6: CDB tag width; tag 0 means "value valid / no producer"
- BASE_TAG, 1: tag of station 0; station i has tag BASE_TAG+i (must be nonzero, BASE_TAG+N_RS-1 < 2^TAG_W)
- LATENCY, 2: ALU execute cycles (>=1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue  in  1  issue request this cycle
- opcode  in  3  ALU operation
- A, B  in  DATA_W  operand value, or producer tag in [TAG_W-1:0] when *_invalid
- A_invalid, B_invalid  in  1  operand is a tag, not a value
- available  out  1  at least one station free
- issued  out  TAG_W  tag of station accepting issue, one-cycle pulse, else 0
- error  out  1  one-cycle pulse: issue rejected
- cdb_write  in  1  CDB carries a valid result this cycle
- cdb_tag  in  TAG_W  producer tag on CDB
- cdb_data  in  DATA_W  result on CDB
- cdb_req  out  1  result ready, requesting CDB
- cdb_grant  in  1  arbiter grant; result_* are driven onto the CDB this cycle
- result_tag  out  TAG_W  tag of completing station
- result_data  out  DATA_W  computed result
- executing  out  TAG_W  tag of station in ALU, 0 if idle

## Operation
- Opcodes: ADD 000, SUB 001, OR 100, AND 101, NOT 110 (~Vj), XOR 111. 010/011 are illegal.
- Arithmetic is modulo 2^DATA_W. There is no overflow flag.
- Station state: busy, op, Qj/Qk (tag), Vj/Vk. A station is ready when busy, Qj==0, Qk==0 and not in flight.
- Issue, sampled at edge when issue=1:
  - Illegal opcode, or no free station: reject. error=1, issued=0, no state change.
  - Otherwise allocate the first free station scanning from the rotating pointer prio, wrapping. issued=its tag.
  - Operand with *_invalid=0: Q=0, V=value.
  - Operand with *_invalid=1: Q=tag. If cdb_write and cdb_tag equals that tag in the same cycle, capture cdb_data instead and set Q=0 (issue-time forwarding).
  - For NOT, Qk is forced to 0 and B is ignored.
- Snoop: each edge with cdb_write=1, every busy station with Qj==cdb_tag (nonzero) loads Vj and clears Qj. Qk is handled the same way. Both operands may match at once.
- Unit FSM:
  - IDLE: if any station is ready, select the first ready station from prio, compute its result, go to EXEC. executing=tag.
  - EXEC: count LATENCY-1 further cycles, then go to WAIT.
  - WAIT: cdb_req=1, result_tag/result_data held stable. On cdb_grant: free the station, advance prio to index+1 mod N_RS, go to IDLE.
- A freed station becomes visible in `available` the next cycle. An issue in the grant cycle sees pre-release occupancy.
- A station's own broadcast is snooped like any other CDB result, which allows back-to-back dependent instructions.
- cdb_grant outside WAIT is ignored.

## Timing
- Reset: all stations free, prio=0, FSM=IDLE, available=1, issued=0, error=0, cdb_req=0, result_tag=0, result_data=0, executing=0.
- Reset mid-operation discards all stations and any pending result. cdb_req drops at the reset edge.
- Latency: operands complete at edge k. Dispatch at edge k+1 (if IDLE). cdb_req asserts after edge k+1+LATENCY.
- Minimum re-dispatch after grant is 1 cycle (IDLE for one cycle).
- issued and error are registered pulses, valid for the cycle after the sampling edge.
- Simultaneous issue and snoop on the same tag: forwarding applies. Simultaneous issue and grant: both take effect.

## Structure
- Package rs_pkg: opcode localparams (OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_XOR), TAG_NONE=0, FSM state encoding (IDLE, EXEC, WAIT).
- One sub-module, rs_alu_core: combinational DATA_W-parametrised op/Vj/Vk to result, with an illegal-op flag.
- The rotating-priority search is a function inside rs_alu_unit.

## Test plan
- Reset, then issue ADD A=5, B=7, both valid, LATENCY=2 -> issued=1 next cycle; cdb_req rises 3 edges after issue; grant -> result_tag=1, result_data=12, available=1.
- Fill all 3 stations with A_invalid tag=9, then issue again -> 4th issue gives error=1, issued=0, available=0. Drive cdb_write tag 9, data 4 -> all three become ready and complete in order 1,2,3 via the rotating pointer.
- Issue SUB with A_invalid tag=5 in the same cycle that cdb_write tag=5 data=10, B=3 -> forwarded; result 7.
- Issue opcode 010 -> error=1, no station allocated.
- SUB 0-1 with DATA_W=8 -> result 0xFF. NOT A=0x0F, B_invalid=1 tag 7 -> result 0xF0 with no wait on tag 7.
- Assert reset while cdb_req=1 with two stations busy -> next cycle cdb_req=0, available=1, executing=0. A later grant has no effect.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared opcode, tag and FSM definitions for the
// reservation-station ALU functional unit.
package rs_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int TAG_NONE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return !(op == 3'b010 || op == 3'b011);
  endfunction

endpackage

// File: rtl/rs_alu_core.sv
// Combinational integer ALU datapath.
// Flags encodings that have no operation.
import rs_pkg::*;

module rs_alu_core #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              illegal
);

  always_comb begin
    y       = a;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): y = a + b;
      (op == OP_SUB): y = a - b;
      (op == OP_OR):  y = a | b;
      (op == OP_AND): y = a & b;
      (op == OP_NOT): y = ~a;
      (op == OP_XOR): y = a ^ b;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rs_alu_unit.sv
// ALU functional unit with N_RS reservation stations,
// CDB snooping and a single multi-cycle execute slot.
import rs_pkg::*;

module rs_alu_unit #(
  parameter int N_RS     = 3,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 6,
  parameter int BASE_TAG = 1,
  parameter int LATENCY  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              A_invalid,
  input  logic              B_invalid,
  output logic              available,
  output logic [TAG_W-1:0]  issued,
  output logic              error,
  input  logic              cdb_write,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  result_tag,
  output logic [DATA_W-1:0] result_data,
  output logic [TAG_W-1:0]  executing
);

  localparam int IDX_W = (N_RS > 1) ? $clog2(N_RS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [N_RS-1:0]   busy_q, busy_d;
  logic [2:0]        op_q [N_RS];
  logic [2:0]        op_d [N_RS];
  logic [TAG_W-1:0]  qj_q [N_RS];
  logic [TAG_W-1:0]  qj_d [N_RS];
  logic [TAG_W-1:0]  qk_q [N_RS];
  logic [TAG_W-1:0]  qk_d [N_RS];
  logic [DATA_W-1:0] vj_q [N_RS];
  logic [DATA_W-1:0] vj_d [N_RS];
  logic [DATA_W-1:0] vk_q [N_RS];
  logic [DATA_W-1:0] vk_d [N_RS];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  prio_q, prio_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  issued_q, issued_d;
  logic              error_q, error_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [TAG_W-1:0]  exec_q, exec_d;

  logic [N_RS-1:0]   rdy_m, free_m;
  logic [IDX_W:0]    rd_pick, fr_pick;
  logic [IDX_W-1:0]  rd_idx, fr_idx;
  logic              rd_found, fr_found;
  logic [DATA_W-1:0] core_y;
  logic              core_ill;

  // First set bit of m, scanning upward from p and wrapping.
  function automatic logic [IDX_W:0] pick(
    input logic [N_RS-1:0]  m,
    input logic [IDX_W-1:0] p
  );
    logic [IDX_W:0] r;
    int k;
    r = '0;
    for (int i = N_RS - 1; i >= 0; i--) begin
      k = (int'(p) + i) % N_RS;
      if (m[k]) r = {1'b1, IDX_W'(k)};
    end
    return r;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [IDX_W-1:0] idx
  );
    return TAG_W'(BASE_TAG) + TAG_W'(idx);
  endfunction

  always_comb begin
    for (int i = 0; i < N_RS; i++) begin
      free_m[i] = !busy_q[i];
      rdy_m[i]  = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 &&
                  !(state_q != IDLE && sel_q == IDX_W'(i));
    end
  end

  assign rd_pick  = pick(rdy_m, prio_q);
  assign fr_pick  = pick(free_m, prio_q);
  assign rd_found = rd_pick[IDX_W];
  assign rd_idx   = rd_pick[IDX_W-1:0];
  assign fr_found = fr_pick[IDX_W];
  assign fr_idx   = fr_pick[IDX_W-1:0];

  rs_alu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .op      (op_q[rd_idx]),
    .a       (vj_q[rd_idx]),
    .b       (vk_q[rd_idx]),
    .y       (core_y),
    .illegal (core_ill)
  );

  always_comb begin
    busy_d     = busy_q;
    op_d       = op_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    state_d    = state_q;
    prio_d     = prio_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    issued_d   = '0;
    error_d    = 1'b0;
    res_tag_d  = res_tag_q;
    res_data_d = res_data_q;
    exec_d     = exec_q;

    if (cdb_write && cdb_tag != '0) begin
      for (int i = 0; i < N_RS; i++) begin
        if (busy_q[i] && qj_q[i] == cdb_tag) begin
          qj_d[i] = '0;
          vj_d[i] = cdb_data;
        end
        if (busy_q[i] && qk_q[i] == cdb_tag) begin
          qk_d[i] = '0;
          vk_d[i] = cdb_data;
        end
      end
    end

    if (issue) begin
      if (!op_legal(opcode) || !fr_found) begin
        error_d = 1'b1;
      end else begin
        busy_d[fr_idx] = 1'b1;
        op_d[fr_idx]   = opcode;
        issued_d       = tag_of(fr_idx);
        qj_d[fr_idx]   = '0;
        vj_d[fr_idx]   = A;
        qk_d[fr_idx]   = '0;
        vk_d[fr_idx]   = B;
        if (A_invalid) begin
          if (cdb_write && cdb_tag == A[TAG_W-1:0]) begin
            vj_d[fr_idx] = cdb_data;
          end else begin
            qj_d[fr_idx] = A[TAG_W-1:0];
            vj_d[fr_idx] = '0;
          end
        end
        if (opcode == OP_NOT) begin
          vk_d[fr_idx] = '0;
        end else if (B_invalid) begin
          if (cdb_write && cdb_tag == B[TAG_W-1:0]) begin
            vk_d[fr_idx] = cdb_data;
          end else begin
            qk_d[fr_idx] = B[TAG_W-1:0];
            vk_d[fr_idx] = '0;
          end
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rd_found) begin
          state_d    = EXEC;
          sel_d      = rd_idx;
          cnt_d      = CNT_W'(LATENCY - 1);
          res_tag_d  = tag_of(rd_idx);
          res_data_d = core_ill ? '0 : core_y;
          exec_d     = tag_of(rd_idx);
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = WAIT;
        else cnt_d = cnt_q - 1'b1;
      end
      WAIT: begin
        if (cdb_grant) begin
          busy_d[sel_q] = 1'b0;
          prio_d  = (sel_q == IDX_W'(N_RS - 1)) ? '0
                                                : sel_q + 1'b1;
          state_d = IDLE;
          exec_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q     <= '0;
      state_q    <= IDLE;
      prio_q     <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      error_q    <= 1'b0;
      res_tag_q  <= '0;
      res_data_q <= '0;
      exec_q     <= '0;
      for (int i = 0; i < N_RS; i++) begin
        op_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      state_q    <= state_d;
      prio_q     <= prio_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      error_q    <= error_d;
      res_tag_q  <= res_tag_d;
      res_data_q <= res_data_d;
      exec_q     <= exec_d;
      op_q       <= op_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
    end
  end

  assign available   = |free_m;
  assign issued      = issued_q;
  assign error       = error_q;
  assign cdb_req     = (state_q == WAIT);
  assign result_tag  = res_tag_q;
  assign result_data = res_data_q;
  assign executing   = exec_q;

endmodule

// File: tb/tb_rs_alu_unit.sv
// Directed bench for rs_alu_unit: op table plus
// fill/forwarding/reset sequences.
module tb_rs_alu_unit;

  localparam int DW = 8;
  localparam int TW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          issue;
  logic [2:0]    opcode;
  logic [DW-1:0] A, B;
  logic          A_invalid, B_invalid;
  logic          available;
  logic [TW-1:0] issued;
  logic          error;
  logic          cdb_write;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          cdb_req;
  logic          cdb_grant;
  logic [TW-1:0] result_tag;
  logic [DW-1:0] result_data;
  logic [TW-1:0] executing;

  int n_cmp = 0;
  int n_bad = 0;
  int prio_m = 0;

  rs_alu_unit #(
    .N_RS     (3),
    .DATA_W   (DW),
    .TAG_W    (TW),
    .BASE_TAG (1),
    .LATENCY  (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue       (issue),
    .opcode      (opcode),
    .A           (A),
    .B           (B),
    .A_invalid   (A_invalid),
    .B_invalid   (B_invalid),
    .available   (available),
    .issued      (issued),
    .error       (error),
    .cdb_write   (cdb_write),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_req     (cdb_req),
    .cdb_grant   (cdb_grant),
    .result_tag  (result_tag),
    .result_data (result_data),
    .executing   (executing)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_issue(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic ai,
                          input logic bi);
    issue     = 1'b1;
    opcode    = op;
    A         = a;
    B         = b;
    A_invalid = ai;
    B_invalid = bi;
    tick();
    issue     = 1'b0;
    A_invalid = 1'b0;
    B_invalid = 1'b0;
  endtask

  task automatic wait_req(input string nm, input int exp_lat);
    int n;
    n = 0;
    while (!cdb_req && n < 20) begin
      tick();
      n++;
    end
    check({nm, " latency"}, n, exp_lat);
  endtask

  task automatic grant();
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    prio_m = 0;
  endtask

  initial begin
    reset     = 1'b1;
    issue     = 1'b0;
    opcode    = 3'b000;
    A         = '0;
    B         = '0;
    A_invalid = 1'b0;
    B_invalid = 1'b0;
    cdb_write = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    cdb_grant = 1'b0;

    vecs[0] = '{"add 5+7",   3'b000, 8'h05, 8'h07, 8'h0C};
    vecs[1] = '{"sub 0-1",   3'b001, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{"sub 10-3",  3'b001, 8'h0A, 8'h03, 8'h07};
    vecs[3] = '{"or",        3'b100, 8'hF0, 8'h0C, 8'hFC};
    vecs[4] = '{"and",       3'b101, 8'hF0, 8'h3C, 8'h30};
    vecs[5] = '{"not",       3'b110, 8'h0F, 8'h55, 8'hF0};
    vecs[6] = '{"xor",       3'b111, 8'hAA, 8'hFF, 8'h55};
    vecs[7] = '{"add wrap",  3'b000, 8'hFF, 8'h02, 8'h01};

    do_reset();
    check("rst available", available, 1);
    check("rst issued", issued, 0);
    check("rst error", error, 0);
    check("rst cdb_req", cdb_req, 0);
    check("rst result_tag", result_tag, 0);
    check("rst result_data", result_data, 0);
    check("rst executing", executing, 0);

    for (int i = 0; i < 8; i++) begin
      do_issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
      check({vecs[i].name, " issued"}, issued, 1 + prio_m);
      check({vecs[i].name, " error"}, error, 0);
      wait_req(vecs[i].name, 3);
      check({vecs[i].name, " executing"}, executing, 1 + prio_m);
      check({vecs[i].name, " tag"}, result_tag, 1 + prio_m);
      check({vecs[i].name, " data"}, result_data, vecs[i].exp);
      grant();
      check({vecs[i].name, " avail"}, available, 1);
      check({vecs[i].name, " req drop"}, cdb_req, 0);
      prio_m = (prio_m + 1) % 3;
    end

    // illegal opcode
    do_issue(3'b010, 8'h01, 8'h01, 1'b0, 1'b0);
    check("illegal error", error, 1);
    check("illegal issued", issued, 0);
    tick();
    check("illegal error pulse", error, 0);
    tick();
    tick();
    check("illegal no dispatch", executing, 0);
    check("illegal no req", cdb_req, 0);

    // fill all stations with operands pending on tag 9
    do_reset();
    do_issue(3'b000, 8'd9, 8'd1, 1'b1, 1'b0);
    check("fill issued 1", issued, 1);
    do_issue(3'b000, 8'd9, 8'd2, 1'b1, 1'b0);
    check("fill issued 2", issued, 2);
    do_issue(3'b000, 8'd9, 8'd3, 1'b1, 1'b0);
    check("fill issued 3", issued, 3);
    check("fill avail 0", available, 0);
    do_issue(3'b000, 8'd1, 8'd1, 1'b0, 1'b0);
    check("full error", error, 1);
    check("full issued", issued, 0);
    check("full avail", available, 0);
    tick();
    tick();
    check("pending no dispatch", executing, 0);
    cdb_write = 1'b1;
    cdb_tag   = 6'd9;
    cdb_data  = 8'd4;
    tick();
    cdb_write = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wait_req("fill", 3);
      check("fill order tag", result_tag, j + 1);
      check("fill data", result_data, 5 + j);
      grant();
    end
    check("fill drained avail", available, 1);
    prio_m = 0;

    // issue-time forwarding
    cdb_write = 1'b1;
    cdb_tag   = 6'd5;
    cdb_data  = 8'd10;
    do_issue(3'b001, 8'd5, 8'd3, 1'b1, 1'b0);
    cdb_write = 1'b0;
    check("fwd issued", issued, 1);
    wait_req("fwd", 3);
    check("fwd data", result_data, 8'h07);
    grant();

    // NOT ignores a pending B
    do_issue(3'b110, 8'h0F, 8'd7, 1'b0, 1'b1);
    check("not issued", issued, 2);
    wait_req("not", 3);
    check("not data", result_data, 8'hF0);
    check("not tag", result_tag, 2);
    grant();

    // reset while a result is pending
    do_issue(3'b000, 8'd1, 8'd1, 1'b0, 1'b0);
    check("mid issued a", issued, 3);
    do_issue(3'b000, 8'd20, 8'd1, 1'b1, 1'b0);
    check("mid issued b", issued, 1);
    wait_req("mid", 2);
    check("mid req", cdb_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid rst req", cdb_req, 0);
    check("mid rst avail", available, 1);
    check("mid rst exec", executing, 0);
    check("mid rst tag", result_tag, 0);
    grant();
    check("late grant req", cdb_req, 0);
    tick();
    tick();
    check("late grant exec", executing, 0);
    do_issue(3'b000, 8'd2, 8'd3, 1'b0, 1'b0);
    check("post rst issued", issued, 1);
    wait_req("post rst", 3);
    check("post rst data", result_data, 8'd5);
    grant();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
